// File: rtl/ones_gen_pkg.sv
// Shared parameters and controller state encoding for the ones generator.
package ones_gen_pkg;

  // Width of the generated word (register R1).
  localparam int data_size = 8;
  // Width of the requested count and of the down-counter R2.
  localparam int r2_size = $clog2(data_size + 1);

  // Largest count that fits in R1; used as the clip value.
  localparam logic [r2_size-1:0] max_cnt = r2_size'(data_size);

  // One-hot controller states.
  typedef enum logic [1:0] {
    S_idle = 2'b01,
    S_1    = 2'b10
  } state_t;

endpackage

// File: rtl/ones_gen_controller.sv
// One-hot controller for the ones generator: waits for start, then keeps
// requesting shifts until the datapath down-counter reaches zero.
module ones_gen_controller
  import ones_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       zero,
  output logic [1:0] Q_out,
  output logic       load_regs,
  output logic       shift_dec,
  output logic       rdy
);

  state_t state;
  state_t state_next;

  // State register; reset forces the idle state asynchronously.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_idle;
    else     state <= state_next;
  end

  // Next-state logic; illegal encodings fall back to idle.
  // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = S_idle;
    case (state)
      S_idle:  state_next = start ? S_1 : S_idle;
      S_1:     state_next = zero ? S_idle : S_1;
      default: state_next = S_idle;
    endcase
  end

  // Output decode from the state register (rdy has no path from start).
  always_comb begin
    Q_out     = state;
    rdy       = (state == S_idle);
    load_regs = (state == S_idle) && start;
    shift_dec = (state == S_1) && !zero;
  end

endmodule

// File: rtl/ones_gen.sv
// Ones generator top: builds a right-justified thermometer code with the
// requested number of ones by shifting 1s into R1 while R2 counts down.
// Optional feature: define ONES_GEN_SAT_EN to clip over-range requests to
// data_size and flag them on ovf; otherwise ovf is tied low.
module ones_gen
  import ones_gen_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [r2_size-1:0]   cnt_in,
  output logic [data_size-1:0] data_out,
  output logic                 rdy,
  output logic                 ovf
);

  logic [data_size-1:0] r1;
  logic [r2_size-1:0]   r2;
  logic [r2_size-1:0]   load_val;
  logic [1:0]           q_out;
  logic                 zero;
  logic                 load_regs;
  logic                 shift_dec;
  logic                 state_bad;

  assign zero      = (r2 == '0);
  assign state_bad = (q_out != S_idle) && (q_out != S_1);

  ones_gen_controller controller_0 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .zero      (zero),
    .Q_out     (q_out),
    .load_regs (load_regs),
    .shift_dec (shift_dec),
    .rdy       (rdy)
  );

`ifdef ONES_GEN_SAT_EN
  logic over;
  logic ovf_q;

  // Clip the request to the word width and remember that it was clipped.
  always_comb begin
    over     = (cnt_in > max_cnt);
    load_val = over ? max_cnt : cnt_in;
  end

  // Overflow flag updates with every accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ovf_q <= 1'b0;
    else if (load_regs) ovf_q <= over;
  end

  assign ovf = ovf_q;
`else
  assign load_val = cnt_in;
  assign ovf      = 1'b0;
`endif

  // R1/R2 datapath: load on start, shift a 1 in and decrement while nonzero.
  // A corrupted controller state clears the datapath so no stale word survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1 <= '0;
      r2 <= '0;
    end else if (state_bad) begin
      r1 <= '0;
      r2 <= '0;
    end else if (load_regs) begin
      r1 <= '0;
      r2 <= load_val;
    end else if (shift_dec) begin
      r1 <= {r1[data_size-2:0], 1'b1};
      r2 <= r2 - 1'b1;
    end
  end

  assign data_out = r1;

endmodule

// File: tb/tb_ones_gen.sv
// Directed self-checking bench for ones_gen: reset, single runs, over-range
// request, back-to-back runs with start held high, and reset mid-run.
module tb_ones_gen;
  import ones_gen_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic [r2_size-1:0]   cnt_in = '0;
  logic [data_size-1:0] data_out;
  logic                 rdy;
  logic                 ovf;

  int n_vec = 0;
  int n_err = 0;

  ones_gen dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cnt_in   (cnt_in),
    .data_out (data_out),
    .rdy      (rdy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference popcount, independent of the thermometer formula.
  function automatic int ref_ones(input logic [data_size-1:0] w);
    int c = 0;
    for (int i = 0; i < data_size; i++) if (w[i]) c++;
    return c;
  endfunction

  // Count negedges with rdy low after the start edge; returns -1 on timeout.
  task automatic count_low(output int low);
    low = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rdy) return;
      low++;
    end
    low = -1;
  endtask

  // One run from idle: called at a negedge with rdy high.
  task automatic run(input string tag, input int n, input logic [7:0] exp_data,
                     input logic exp_ovf, input int exp_low);
    int low;
    cnt_in = r2_size'(n);
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    count_low(low);
    check({tag, "_low"}, low, exp_low);
    check({tag, "_data"}, data_out, exp_data);
    check({tag, "_ovf"}, ovf, exp_ovf);
  endtask

  initial begin
    int low;
    logic [7:0] exp_w;

    // Reset with no clock edge in between (first edge is at t=5).
    #1 rst = 1'b1;
    #2;
    check("rst_rdy", rdy, 1);
    check("rst_data", data_out, 8'h00);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run("n0", 0, 8'h00, 1'b0, 1);
    run("n3", 3, 8'h07, 1'b0, 4);
    run("n8", 8, 8'hFF, 1'b0, 9);
`ifdef ONES_GEN_SAT_EN
    run("n12", 12, 8'hFF, 1'b1, 9);
    run("n1_ovf_clr", 1, 8'h01, 1'b0, 2);
`else
    run("n12", 12, 8'hFF, 1'b0, 13);
    run("n1", 1, 8'h01, 1'b0, 2);
`endif

    // start held high; cnt_in advanced during each one-cycle idle window.
    start = 1'b1;
    for (int n = 0; n <= 8; n++) begin
      cnt_in = r2_size'(n);
      @(posedge clk);
      count_low(low);
      exp_w = '0;
      for (int i = 0; i < n; i++) exp_w[i] = 1'b1;
      check($sformatf("b2b%0d_low", n), low, n + 1);
      check($sformatf("b2b%0d_data", n), data_out, exp_w);
      check($sformatf("b2b%0d_pop", n), ref_ones(data_out), n);
    end
    start = 1'b0;
    @(negedge clk);
    check("b2b_end_rdy", rdy, 1);
    check("b2b_end_data", data_out, 8'hFF);

    // Reset during an n=5 run after two shifts.
    cnt_in = 4'd5;
    start  = 1'b1;
    @(posedge clk);           // E0: load
    #1 start = 1'b0;
    @(posedge clk);           // E1: first shift
    @(posedge clk);           // E2: second shift
    #2;
    check("mid_rdy", rdy, 0);
    check("mid_data", data_out, 8'h03);
    rst = 1'b1;
    #1;
    check("abort_rdy", rdy, 1);
    check("abort_data", data_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run("after_rst", 2, 8'h03, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/ones_gen.md
# ones_gen

Ones generator: the inverse of the ones-counter datapath. Given a count `n` on `cnt_in`, it builds a `data_size`-bit word with exactly `n` ones, right-justified as a thermometer code (`(1<<n)-1`). The block shifts 1s into a register while decrementing a counter. It is split into a one-hot controller and a register datapath, and sits next to the ones counter so that a counter → generator loopback can be built with the same `start`/`rdy` handshake.

## Interface
Parameters come from `ones_gen_pkg`:
- `data_size`, 8: width of the generated word (`data_out`, register R1).
- `r2_size`, `$clog2(data_size+1)` = 4: width of `cnt_in` and of the down-counter R2.

Ports:
- `clk`  input  1  single clock; rising-edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `start`  input  1  request; sampled only in `S_idle`.
- `cnt_in`  input  `r2_size`  requested number of ones; sampled with `start`.
- `data_out`  output  `data_size`  R1 contents; holds the result while `rdy`=1.
- `rdy`  output  1  high exactly when the state is `S_idle`.
- `ovf`  output  1  request was clipped (`cnt_in` > `data_size`); see Configuration.

## Operation
- Controller states, one-hot, `Q_out[1:0]`:
  - `S_idle` = 2'b01
  - `S_1` = 2'b10
- Controller status input: `zero` = (R2 == 0).
- Controller outputs:
  - `load_regs` = `S_idle` & `start`
  - `shift_dec` = `S_1` & !`zero`
- `S_idle`:
  - `rdy`=1.
  - If `start`: R1 ← 0, R2 ← `cnt_in` (clipped per Configuration), `ovf` updated; next state `S_1`.
  - Otherwise all registers hold.
- `S_1`:
  - `rdy`=0.
  - If !`zero`: R1 ← {R1[`data_size`-2:0], 1'b1}, R2 ← R2-1; stay in `S_1`.
  - If `zero`: registers hold; next state `S_idle`.
- Result on return to `S_idle`: `data_out` = `(1<<n)-1` and `$countones(data_out)` = `n`, where `n` is the loaded R2 value.
- Arithmetic rules:
  - R2 decrements only when nonzero, so it never wraps.
  - Ones shifted past the MSB of R1 are discarded.
- `start` held high: the block reloads on the first edge after returning to `S_idle`, so `rdy` is high for exactly one cycle between back-to-back runs.
- `start` while in `S_1`: ignored; `cnt_in` changes while in `S_1` have no effect.
- An illegal one-hot state (00 or 11) goes to `S_idle` on the next edge.

## Timing
- Reset values, applied immediately on `rst`=1 regardless of the clock:
  - state `S_idle`, `rdy`=1
  - R1=0, so `data_out`=0
  - R2=0, `ovf`=0
- Reset mid-run aborts the run: `rdy` rises and `data_out` clears asynchronously, and no partial result is held.
- Latency: `start` sampled at edge E0 → `rdy` falls after E0 → shifts occur on E1..En → `zero` is sensed at En+1 → `rdy` rises after En+1.
  - The start edge to `rdy` high takes `n`+2 edges.
  - `rdy` is low for `n`+1 cycles.
- `n`=0: `rdy` low for 1 cycle; `data_out`=0.
- `rdy` is a decode of the state register only (glitch-free, no combinational path from `start`).
- `data_out` is stable throughout `S_idle`. During `S_1` it shows intermediate values that must not be consumed.

## Configuration
- Macro `ONES_GEN_SAT_EN`:
  - Defined:
    - When `cnt_in` > `data_size`, R2 loads `data_size` and `ovf` ← 1.
    - Otherwise `ovf` ← 0.
    - Worst-case latency is `data_size`+2.
  - Undefined:
    - R2 loads `cnt_in` unmodified and `ovf` is tied to 0.
    - Over-range requests still yield all-ones, but the latency is `cnt_in`+2 (up to 17 edges).

## Structure
- `ones_gen_pkg` holds:
  - `data_size`, `r2_size`
  - the state typedef/localparams `S_idle`, `S_1` (one-hot)
- One sub-module, `ones_gen_controller`, instanced as `controller_0`:
  - inputs: `clk`, `rst`, `start`, `zero`
  - outputs: `Q_out`, `load_regs`, `shift_dec`, `rdy`
- The datapath (R1, R2, `ovf`, `zero` detect, clip logic) lives in the top `ones_gen`.

## Test plan
- Reset: assert `rst` with no clock edge → `rdy`=1, `data_out`=8'h00, `ovf`=0.
- `cnt_in`=0, `start` pulse → `rdy` low for 1 cycle, `data_out`=8'h00.
- `cnt_in`=3 → `rdy` low for 4 cycles, `data_out`=8'h07. `cnt_in`=8 → `rdy` low for 9 cycles, `data_out`=8'hFF.
- `cnt_in`=12:
  - with `ONES_GEN_SAT_EN` → 8'hFF, `ovf`=1, `rdy` low for 9 cycles;
  - without it → 8'hFF, `ovf`=0, `rdy` low for 13 cycles.
- `start` held high while `cnt_in` increments 0..8 on each `posedge rdy` → each result equals `(1<<n)-1`, and `$countones` matches the ones-counter reference. `rdy` is high for 1 cycle between runs.
- Assert `rst` during the `n`=5 run after 2 shifts → `rdy`=1 and `data_out`=0 immediately; the next run with `n`=2 → `data_out`=8'h03.
